wb_write_port: RTL
==================

# wb_write_port

Writeback arbiter that owns the register file's single write port. It merges one-cycle ALU results with variable-latency load responses. Load responses are sign- or zero-extended and buffered in a small queue. ALU results have priority, with an age-based guard that keeps loads from starving. The registered outputs drive the register file's `reg_write`, `rd_addr` and `write_data` inputs directly.

## Interface
- `DEPTH`, 4: load-queue entries; must be a power of two, at least 2.
- `STARVE_LIMIT`, 3: consecutive cycles a queue head may lose to the ALU before it is forced through (1..15).
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_ready` out 1: write port grants the ALU this cycle.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `ld_valid` in 1: load response present.
- `ld_ready` out 1: queue can accept the load.
- `ld_rd` in 5: load destination register.
- `ld_data` in 32: aligned memory word.
- `ld_funct3` in 3: load type.
- `ld_off` in 2: byte offset within the word.
- `reg_write` out 1: write enable to the register file.
- `rd_addr` out 5: write address to the register file.
- `write_data` out 32: write data to the register file.
- `busy` out 1: load queue is non-empty.

## Operation
- **Load acceptance:** a load is accepted when `ld_valid && ld_ready`. `ld_ready = !full`; a pop in the same cycle does not free a slot for this cycle's push.
- **Load extension**, applied before enqueue:
  - Byte select is `ld_data[8*ld_off +: 8]`.
  - Half select is `ld_off[1] ? ld_data[31:16] : ld_data[15:0]`; `ld_off[0]` is ignored for halves.
  - funct3 000 (LB): sign-extended byte.
  - funct3 001 (LH): sign-extended half.
  - funct3 100 (LBU): zero-extended byte.
  - funct3 101 (LHU): zero-extended half.
  - funct3 010, 011, 110, 111: full word.
- **Register 0 loads:** an accepted load with `ld_rd == 0` is consumed and dropped. It does not occupy a queue slot.
- **ALU acceptance:** an ALU result is accepted when `alu_valid && alu_ready`. The upstream holds the result while `alu_ready` is low.
- **Register 0 ALU results:** an accepted result with `alu_rd == 0` is dropped and does not claim the port.
- **Port selection, each cycle:**
  1. If `force` is set, pop the queue head. `force = !empty && age == STARVE_LIMIT`, and `alu_ready = !force`.
  2. Otherwise, if an ALU result is accepted with `alu_rd != 0`, the ALU wins.
  3. Otherwise, if the queue is non-empty, pop the head.
  4. Otherwise, the port is idle.
- **Age counter:**
  - Increments in each cycle the head is non-empty and loses to a non-zero ALU write.
  - Clears to 0 on every pop.
  - Holds when the queue is empty.
- **Outputs:**
  - Selected `rd` and data are registered into `rd_addr` and `write_data`, with `reg_write = 1`.
  - When idle, `reg_write = 0` and `rd_addr`/`write_data` hold their last values.
  - `reg_write` is never 1 while `rd_addr == 0`.
- **Ordering:** writes to the same `rd` are not reordered within the queue, which is FIFO. ALU-versus-load ordering to the same `rd` is the issue logic's responsibility.

## Timing
- **Reset** (asynchronous, active-low):
  - `reg_write = 0`, `rd_addr = 0`, `write_data = 0`.
  - Queue empty; `age = 0`; `busy = 0`.
  - `ld_ready = 1`, `alu_ready = 1` during and after reset.
- **Reset mid-operation:** queued loads are discarded, and any pending write is dropped.
- **ALU latency:** a result accepted in cycle N appears as `reg_write = 1` in N+1. The register file commits it at the end of N+1.
- **Load latency:** a load accepted in cycle N into an empty queue, with no ALU contention, is enqueued at the end of N, popped in N+1, and drives `reg_write = 1` in N+2.
- **Throughput:** at most one write per cycle.
- **Sustained pressure:** with continuous ALU traffic and a non-empty queue, one load is forced every `STARVE_LIMIT + 1` cycles.
- **Full queue:** `ld_ready` deasserts combinationally when the count equals `DEPTH`. Simultaneous push and pop is allowed whenever not full, and the count is unchanged.
- **Pointers and count:** pointers wrap modulo `DEPTH`. Count width is `log2(DEPTH) + 1`.
- **Busy flag:** `busy` reflects the queue state combinationally from the registered count.

## Test plan
- **Idle ALU write:** reset, then `alu_valid = 1`, `alu_rd = 5`, `alu_data = 0xDEADBEEF` in cycle 1 -> cycle 2 shows `reg_write = 1`, `rd_addr = 5`, `write_data = 0xDEADBEEF`. Cycle 3 shows `reg_write = 0`.
- **Extension matrix:** `ld_data = 0x80F17F01` with LB offset 2 -> 0xFFFFFFF1; LBU offset 3 -> 0x00000080; LH offset 2 -> 0xFFFF80F1; LHU offset 0 -> 0x00007F01; funct3 010 -> 0x80F17F01. Each appears 2 cycles after acceptance.
- **Register 0 suppression:** `alu_rd = 0` and `ld_rd = 0` offered back-to-back -> `reg_write` is never asserted and `busy` stays 0.
- **Full queue:** continuous ALU traffic to `rd = 1` while pushing 5 loads with `DEPTH = 4` -> `ld_ready` drops after the 4th accept. The 5th load is held and accepted only after a pop. Loads exit in FIFO order.
- **Starvation guard:** `STARVE_LIMIT = 3`, one queued load, continuous `alu_valid` -> the ALU wins for 3 cycles. In the 4th cycle `alu_ready = 0` and the load writes the next cycle. `age` returns to 0.
- **Reset mid-operation:** assert `rst_n = 0` asynchronously with 3 loads queued and `reg_write = 1` -> outputs are 0 immediately, and `busy = 0` and `ld_ready = 1` after release.

Source files
------------

// File: rtl/wb_write_port.sv
// Writeback arbiter for the register file's single write port.
// It merges one-cycle ALU results with load responses that have been extended and queued.
module wb_write_port #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  output logic        reg_write,
  output logic [4:0]  rd_addr,
  output logic [31:0] write_data,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    q_rd_q   [DEPTH];
  logic [31:0]   q_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    age_q, age_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   write_data_q, write_data_d;

  logic          empty, full, force_pop, push, pop, alu_win;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_ext;

  // Loads are extended on the way in, so the queue holds final register values.
  always_comb begin
    byte_sel = ld_data[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? ld_data[31:16] : ld_data[15:0];
    case (ld_funct3)
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_ext = {24'b0, byte_sel};
      3'b101:  ld_ext = {16'b0, half_sel};
      default: ld_ext = ld_data;
    endcase
  end

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign force_pop = !empty && (age_q == 4'(STARVE_LIMIT));
  assign alu_ready = !force_pop;
  assign ld_ready  = !full;
  assign busy      = !empty;
  assign push      = ld_valid && !full && (ld_rd != 5'd0);
  assign alu_win   = alu_valid && !force_pop && (alu_rd != 5'd0);
  // A forced pop always beats the ALU, so force_pop already implies !alu_win.
  assign pop       = !empty && !alu_win;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    age_d        = age_q;
    reg_write_d  = 1'b0;
    rd_addr_d    = rd_addr_q;
    write_data_d = write_data_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pop)                   age_d = '0;
    else if (!empty && alu_win) age_d = age_q + 4'd1;
    if (pop) begin
      reg_write_d  = 1'b1;
      rd_addr_d    = q_rd_q[rd_ptr_q];
      write_data_d = q_data_q[rd_ptr_q];
    end else if (alu_win) begin
      reg_write_d  = 1'b1;
      rd_addr_d    = alu_rd;
      write_data_d = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd_q[wr_ptr_q]   <= ld_rd;
      q_data_q[wr_ptr_q] <= ld_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      age_q        <= '0;
      reg_write_q  <= 1'b0;
      rd_addr_q    <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      age_q        <= age_d;
      reg_write_q  <= reg_write_d;
      rd_addr_q    <= rd_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign rd_addr    = rd_addr_q;
  assign write_data = write_data_q;
endmodule
